// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the MIO bus arbiter: FSM state encoding and abort defaults.
package mio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_e;

  localparam logic [31:0] ABORT_RDATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mio_bus_arbiter.sv
// Arbitrates the single MIO memory port between the IF (fetch) and MEM (lw/sw) stages,
// with fixed MEM priority, a per-transaction timeout and per-stage stall outputs.
module mio_bus_arbiter
  import mio_bus_arbiter_pkg::*;
#(
  parameter int          TIMEOUT     = 256,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] ABORT_RDATA = ABORT_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mio_req,
  output logic        mio_we,
  output logic [31:0] mio_addr,
  output logic [31:0] mio_wdata,
  input  logic [31:0] mio_rdata,
  input  logic        MIO_ready,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        bus_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mio_req_d, mio_we_d;
  logic [31:0]       mio_addr_d, mio_wdata_d;
  logic              if_done_d, mem_done_d;
  logic [31:0]       if_rdata_d, mem_rdata_d;
  logic              bus_timeout_d;

  logic              finish;
  logic              aborted;
  logic [31:0]       bus_result;

  // A requester is only eligible while its own done pulse is low, which
  // stops a still-held request from launching a duplicate access.
  logic              mem_eligible, if_eligible;

  assign mem_eligible = mem_req & ~mem_done;
  assign if_eligible  = if_req & ~if_done;

  assign aborted    = ~MIO_ready & (cnt_q == CNT_LAST);
  assign finish     = MIO_ready | aborted;
  assign bus_result = MIO_ready ? mio_rdata : ABORT_RDATA;

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    mio_req_d     = mio_req;
    mio_we_d      = mio_we;
    mio_addr_d    = mio_addr;
    mio_wdata_d   = mio_wdata;
    if_done_d     = 1'b0;
    mem_done_d    = 1'b0;
    if_rdata_d    = '0;
    mem_rdata_d   = '0;
    bus_timeout_d = bus_timeout;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_eligible) begin
          state_d     = ARB_MEM_BUSY;
          cnt_d       = '0;
          mio_req_d   = 1'b1;
          mio_we_d    = mem_we;
          mio_addr_d  = mem_addr;
          mio_wdata_d = mem_wdata;
        end else if (if_eligible) begin
          state_d     = ARB_IF_BUSY;
          cnt_d       = '0;
          mio_req_d   = 1'b1;
          mio_we_d    = 1'b0;
          mio_addr_d  = if_addr;
          mio_wdata_d = '0;
        end
      end

      ARB_IF_BUSY: begin
        if (finish) begin
          state_d       = ARB_IDLE;
          cnt_d         = '0;
          mio_req_d     = 1'b0;
          mio_we_d      = 1'b0;
          mio_addr_d    = '0;
          mio_wdata_d   = '0;
          if_done_d     = 1'b1;
          if_rdata_d    = bus_result;
          bus_timeout_d = bus_timeout | aborted;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ARB_MEM_BUSY: begin
        if (finish) begin
          state_d       = ARB_IDLE;
          cnt_d         = '0;
          mio_req_d     = 1'b0;
          mio_we_d      = 1'b0;
          mio_addr_d    = '0;
          mio_wdata_d   = '0;
          mem_done_d    = 1'b1;
          // Stores return zero regardless of what the bus drives.
          mem_rdata_d   = mio_we ? 32'h0 : bus_result;
          bus_timeout_d = bus_timeout | aborted;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        cnt_d     = '0;
        mio_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      mio_req     <= 1'b0;
      mio_we      <= 1'b0;
      mio_addr    <= '0;
      mio_wdata   <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      bus_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mio_req     <= mio_req_d;
      mio_we      <= mio_we_d;
      mio_addr    <= mio_addr_d;
      mio_wdata   <= mio_wdata_d;
      if_done     <= if_done_d;
      mem_done    <= mem_done_d;
      if_rdata    <= if_rdata_d;
      mem_rdata   <= mem_rdata_d;
      bus_timeout <= bus_timeout_d;
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: per-cycle vector table plus hand-written
// sequences for timeout, asynchronous reset, held requests and back-to-back gaps.
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mio_req;
  logic        mio_we;
  logic [31:0] mio_addr;
  logic [31:0] mio_wdata;
  logic [31:0] mio_rdata = '0;
  logic        MIO_ready = 1'b0;
  logic        if_stall;
  logic        mem_stall;
  logic        bus_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.TIMEOUT(4), .CNT_W(2), .ABORT_RDATA(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mio_req(mio_req), .mio_we(mio_we), .mio_addr(mio_addr), .mio_wdata(mio_wdata),
    .mio_rdata(mio_rdata), .MIO_ready(MIO_ready),
    .if_stall(if_stall), .mem_stall(mem_stall), .bus_timeout(bus_timeout)
  );

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mio_rdata;
    logic        ready;
  } in_t;

  typedef struct packed {
    logic        mio_req;
    logic        mio_we;
    logic [31:0] mio_addr;
    logic [31:0] mio_wdata;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        mem_stall;
    logic        bus_timeout;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus fields only matter while mio_req is high, read data only while its done is high.
  function automatic out_t observe();
    out_t o;
    o.mio_req     = mio_req;
    o.mio_we      = mio_req ? mio_we : 1'b0;
    o.mio_addr    = mio_req ? mio_addr : 32'h0;
    o.mio_wdata   = (mio_req && mio_we) ? mio_wdata : 32'h0;
    o.if_done     = if_done;
    o.if_rdata    = if_done ? if_rdata : 32'h0;
    o.mem_done    = mem_done;
    o.mem_rdata   = mem_done ? mem_rdata : 32'h0;
    o.if_stall    = if_stall;
    o.mem_stall   = mem_stall;
    o.bus_timeout = bus_timeout;
    return o;
  endfunction

  task automatic drive(input in_t s);
    if_req    = s.if_req;
    if_addr   = s.if_addr;
    mem_req   = s.mem_req;
    mem_we    = s.mem_we;
    mem_addr  = s.mem_addr;
    mem_wdata = s.mem_wdata;
    mio_rdata = s.mio_rdata;
    MIO_ready = s.ready;
  endtask

  task automatic add(input in_t s, input out_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] RD_IF = 32'h2008_0005;
  localparam logic [31:0] RD_2  = 32'h1234_5678;

  initial begin
    in_t  idle_in;
    int   busy, txns, dones, dup, gaps, bad_gaps, lo_run, both_done;
    logic done_seen, prev_req, seen_high;
    logic [31:0] rd;

    idle_in = '0;

    // IF read only, ready on the third bus cycle.
    add('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}, '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}, '{1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}, '{1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, RD_IF, 1'b1}, '{1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}, '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, RD_IF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    add(idle_in, '0);
    // Spurious ready while idle.
    add('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1}, '0);
    add(idle_in, '0);
    // Simultaneous sw and fetch, ready every cycle.
    add('{1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'hCAFE, RD_2, 1'b1}, '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0});
    add('{1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'hCAFE, RD_2, 1'b1}, '{1'b1, 1'b1, 32'h10, 32'hCAFE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0});
    add('{1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'hCAFE, RD_2, 1'b1}, '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, RD_2, 1'b1}, '{1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    add('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, RD_2, 1'b1}, '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, RD_2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    add(idle_in, '0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", observe(), '0);
    check("reset_regs", {mio_we, mio_addr, mio_wdata, if_rdata, mem_rdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].stim);
      #1;
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Timeout: lw with ready held low aborts after 4 busy cycles.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mio_rdata = 32'hBAD0_BAD0; MIO_ready = 1'b0;
    busy = 0; done_seen = 1'b0; rd = 32'hFFFF_FFFF;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      @(negedge clk);
      #1;
      if (mio_req) busy++;
      if (mem_done) begin
        done_seen = 1'b1;
        rd = mem_rdata;
        mem_req = 1'b0;
      end
    end
    check("t3_done_seen", done_seen, 1'b1);
    check("t3_busy_cycles", busy, 4);
    check("t3_abort_rdata", rd, 32'h0);
    check("t3_timeout_flag", bus_timeout, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("t3_timeout_sticky", {bus_timeout, mem_done, mio_req}, 3'b100);

    // Asynchronous reset in the middle of a MEM transaction.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44;
    @(negedge clk);
    #1;
    check("t4_granted", {mio_req, mio_addr}, {1'b1, 32'h44});
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_drop", {mio_req, bus_timeout, mem_done}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t4_regrant", {mio_req, mio_we, mio_addr}, {1'b1, 1'b0, 32'h44});
    mio_rdata = 32'h5555_AAAA; MIO_ready = 1'b1;
    done_seen = 1'b0; rd = '0;
    for (int k = 0; k < 10 && !done_seen; k++) begin
      @(negedge clk);
      #1;
      if (mem_done) begin
        done_seen = 1'b1;
        rd = mem_rdata;
        mem_req = 1'b0;
        MIO_ready = 1'b0;
      end
    end
    check("t4_done_seen", done_seen, 1'b1);
    check("t4_rdata", rd, 32'h5555_AAAA);

    // Held IF request alone: one bus access per done pulse, none in the done cycle.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; MIO_ready = 1'b1; mio_rdata = 32'h0000_0777;
    txns = 0; dones = 0; dup = 0; prev_req = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      #1;
      if (mio_req && !prev_req) txns++;
      if (if_done) begin
        dones++;
        if (mio_req) dup++;
      end
      prev_req = mio_req;
    end
    if_req = 1'b0;
    check("t5_if_txns", txns, 3);
    check("t5_if_dones", dones, 3);
    check("t5_no_dup", dup, 0);

    // Both requests held: alternating grants with a one-cycle bus gap.
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0000_BEEF;
    gaps = 0; bad_gaps = 0; lo_run = 0; seen_high = 1'b0; both_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (if_done && mem_done) both_done++;
      if (mio_req) begin
        if (seen_high) begin
          gaps++;
          if (lo_run != 1) bad_gaps++;
        end
        seen_high = 1'b1;
        lo_run = 0;
      end else begin
        lo_run++;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("t5_gap_count", gaps, 3);
    check("t5_gap_len", bad_gaps, 0);
    check("t5_done_exclusive", both_done, 0);
    repeat (3) @(negedge clk);
    MIO_ready = 1'b0;
    #1;
    check("t5_final_idle", {mio_req, if_done, mem_done, if_stall, mem_stall}, 5'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
